// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Turns a one-transfer-at-a-time command interface into AMBA 3 APB
// SETUP/ACCESS sequences. Wait states from pready are counted, pslverr
// and prdata are captured on the completing edge, and a programmable
// timeout aborts a transfer to a slave that never raises pready.

module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic [7:0]        rsp_waits,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // A timeout beyond the counter range can never fire because the
    // counter saturates at 255; the reported wait count is clamped too.
    localparam int          TIMEOUT_CLAMP = (TIMEOUT > 255) ? 255 : TIMEOUT;
    localparam logic [7:0]  TIMEOUT_WAITS = 8'(TIMEOUT_CLAMP);
    localparam logic [31:0] TIMEOUT_U     = 32'(TIMEOUT);
    localparam logic        TIMEOUT_EN    = (TIMEOUT != 0);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       timeout_hit;
    logic       accept;
    logic       access_done;
    logic       access_abort;

    // Commands are only taken while idle and never while reset is held.
    assign cmd_ready = (state == ST_IDLE) && !preset;
    assign accept    = cmd_valid && cmd_ready;

    // Decode the transfer events and the next FSM state from the current cycle.
    always_comb begin
        wait_inc     = (wait_cnt == 8'hFF) ? 8'hFF : (wait_cnt + 8'd1);
        timeout_hit  = TIMEOUT_EN && ({24'd0, wait_inc} == TIMEOUT_U);
        access_done  = (state == ST_ACCESS) && pready;
        access_abort = (state == ST_ACCESS) && !pready && timeout_hit;
        next_state   = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (access_done || access_abort) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // APB request signals; address, direction and data hold between transfers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (accept) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
        end else if (state == ST_SETUP) begin
            penable <= 1'b1;
        end else if (access_done || access_abort) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    // Count ACCESS edges with pready low, cleared on entry to ACCESS.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= 8'd0;
        end else if ((state == ST_ACCESS) && !pready) begin
            wait_cnt <= wait_inc;
        end
    end

    // Response strobe and status; fields hold until the next response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_waits   <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (access_done) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_slverr  <= pslverr;
                rsp_timeout <= 1'b0;
                rsp_waits   <= wait_cnt;
            end else if (access_abort) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_slverr  <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_waits   <= TIMEOUT_WAITS;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Drives directed and random APB transfers through apb_master_bridge and
// compares responses and bus behaviour against a transfer-level model.

module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;
    localparam int LOOP_LIMIT = 40;

    logic       pclk;
    logic       preset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_slverr;
    logic       rsp_timeout;
    logic [7:0] rsp_waits;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_vec = 0;
    int n_err = 0;

    // Observations recorded by run_transfer for the calling test to judge.
    logic       obs_ready;
    logic       obs_got_rsp;
    int         obs_lat;
    int         obs_psel;
    int         obs_pen;
    logic       obs_stable;
    logic       obs_bus_at_rsp;
    logic [7:0] obs_rdata;
    logic       obs_err;
    logic       obs_to;
    logic [7:0] obs_waits;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] rd;
        logic       err;
        logic       err_wait;
    } xfer_t;

    apb_master_bridge #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .rsp_waits  (rsp_waits),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // Free-running clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Transfer-level model: what one command with a given slave wait count produces.
    function automatic void model(input logic wr, input int waits, input logic [7:0] rd,
                                  input logic err, output logic [7:0] e_rdata,
                                  output logic e_err, output logic e_to,
                                  output logic [7:0] e_waits, output int e_lat,
                                  output int e_psel, output int e_pen);
        logic timed;
        int   eff;
        timed   = (TIMEOUT != 0) && (waits >= TIMEOUT);
        eff     = timed ? TIMEOUT : waits;
        e_waits = (eff > 255) ? 8'hFF : 8'(eff);
        e_lat   = timed ? (eff + 1) : (eff + 2);
        e_psel  = e_lat;
        e_pen   = e_lat - 1;
        e_to    = timed;
        e_err   = timed ? 1'b1 : err;
        e_rdata = (timed || wr) ? 8'h00 : rd;
    endfunction

    // Issue one command (called at a negedge) and act as the slave; returns at
    // the negedge where rsp_valid is seen or after LOOP_LIMIT cycles.
    task automatic run_transfer(input xfer_t x);
        cmd_valid = 1'b1;
        cmd_write = x.wr;
        cmd_addr  = x.addr;
        cmd_wdata = x.wdata;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        obs_ready      = cmd_ready;
        obs_got_rsp    = 1'b0;
        obs_lat        = -1;
        obs_psel       = 0;
        obs_pen        = 0;
        obs_stable     = 1'b1;
        obs_bus_at_rsp = 1'b1;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        for (int i = 0; i < LOOP_LIMIT; i++) begin
            if ((i >= 1) && (i - 1 == x.waits)) begin
                pready  = 1'b1;
                pslverr = x.err;
                prdata  = x.rd;
            end else begin
                pready  = (i == 0) ? 1'($urandom) : 1'b0;
                pslverr = x.err_wait;
                prdata  = 8'($urandom);
            end
            @(negedge pclk);
            if (rsp_valid) begin
                obs_got_rsp    = 1'b1;
                obs_lat        = i;
                obs_bus_at_rsp = psel | penable;
                obs_rdata      = rsp_rdata;
                obs_err        = rsp_slverr;
                obs_to         = rsp_timeout;
                obs_waits      = rsp_waits;
                break;
            end
            if (psel) obs_psel++;
            if (penable) obs_pen++;
            if (psel && ((paddr !== x.addr) || (pwrite !== x.wr) || (pwdata !== x.wdata)))
                obs_stable = 1'b0;
            if (penable && (!psel || (i == 0)))
                obs_stable = 1'b0;
            if (i < LOOP_LIMIT - 1) begin
                @(posedge pclk);
                #1;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    task automatic test_reset();
        preset    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hAA;
        cmd_wdata = 8'h55;
        prdata    = 8'h00;
        pready    = 1'b1;
        pslverr   = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset cmd_ready: got %b expected 0", cmd_ready);
        end
        n_vec++;
        if ({psel, penable, pwrite} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL reset psel/penable/pwrite: got %b expected 000", {psel, penable, pwrite});
        end
        n_vec++;
        if ({paddr, pwdata} !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL reset paddr/pwdata: got %h expected 0000", {paddr, pwdata});
        end
        n_vec++;
        if ({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_waits} !== 19'd0) begin
            n_err++;
            $display("[TB] FAIL reset rsp fields: got %h expected 0",
                     {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_waits});
        end
        preset    = 1'b0;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL post-reset cmd_ready: got %b expected 1", cmd_ready);
        end
        @(negedge pclk);
    endtask

    task automatic test_transfers();
        xfer_t      plan [6];
        xfer_t      x;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_to;
        logic [7:0] e_waits;
        int         e_lat;
        int         e_psel;
        int         e_pen;
        string      tag;
        plan[0] = '{1'b1, 8'h11, 8'h22, 0,  8'h00, 1'b0, 1'b0};
        plan[1] = '{1'b1, 8'h15, 8'h51, 3,  8'h00, 1'b0, 1'b0};
        plan[2] = '{1'b0, 8'h11, 8'h99, 0,  8'h22, 1'b0, 1'b0};
        plan[3] = '{1'b0, 8'h15, 8'h00, 2,  8'h5A, 1'b1, 1'b1};
        plan[4] = '{1'b0, 8'h40, 8'h00, TIMEOUT - 1, 8'hC3, 1'b0, 1'b1};
        plan[5] = '{1'b1, 8'h41, 8'h77, TIMEOUT, 8'h00, 1'b0, 1'b0};
        for (int n = 0; n < 46; n++) begin
            if (n < 6) begin
                x = plan[n];
            end else begin
                int r;
                r          = int'($urandom_range(0, 9));
                x.wr       = 1'($urandom);
                x.addr     = 8'($urandom);
                x.wdata    = 8'($urandom);
                x.waits    = (r == 9) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2)) : (r % 6);
                x.rd       = 8'($urandom);
                x.err      = 1'($urandom);
                x.err_wait = 1'($urandom);
            end
            tag = $sformatf("xfer%0d", n);
            model(x.wr, x.waits, x.rd, x.err, e_rdata, e_err, e_to, e_waits, e_lat, e_psel, e_pen);
            run_transfer(x);
            n_vec++;
            if ((obs_ready !== 1'b1) || (obs_got_rsp !== 1'b1)) begin
                n_err++;
                $display("[TB] FAIL %s handshake: ready=%b rsp_seen=%b expected 1/1", tag, obs_ready, obs_got_rsp);
            end
            n_vec++;
            if (obs_lat != e_lat) begin
                n_err++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", tag, obs_lat, e_lat);
            end
            n_vec++;
            if ((obs_psel != e_psel) || (obs_pen != e_pen)) begin
                n_err++;
                $display("[TB] FAIL %s psel/penable cycles: got %0d/%0d expected %0d/%0d",
                         tag, obs_psel, obs_pen, e_psel, e_pen);
            end
            n_vec++;
            if ((obs_stable !== 1'b1) || (obs_bus_at_rsp !== 1'b0)) begin
                n_err++;
                $display("[TB] FAIL %s bus stability: stable=%b busy_at_rsp=%b expected 1/0",
                         tag, obs_stable, obs_bus_at_rsp);
            end
            n_vec++;
            if (obs_rdata !== e_rdata) begin
                n_err++;
                $display("[TB] FAIL %s rsp_rdata: got %h expected %h", tag, obs_rdata, e_rdata);
            end
            n_vec++;
            if ((obs_err !== e_err) || (obs_to !== e_to)) begin
                n_err++;
                $display("[TB] FAIL %s slverr/timeout: got %b/%b expected %b/%b", tag, obs_err, obs_to, e_err, e_to);
            end
            n_vec++;
            if (obs_waits !== e_waits) begin
                n_err++;
                $display("[TB] FAIL %s rsp_waits: got %0d expected %0d", tag, obs_waits, e_waits);
            end
            if ((n < 6) || ($urandom_range(0, 2) != 0)) begin
                @(posedge pclk);
                #1;
                @(negedge pclk);
                n_vec++;
                if ((rsp_valid !== 1'b0) || (psel !== 1'b0) || (rsp_waits !== e_waits)) begin
                    n_err++;
                    $display("[TB] FAIL %s after response: rsp_valid=%b psel=%b waits=%0d expected 0/0/%0d",
                             tag, rsp_valid, psel, rsp_waits, e_waits);
                end
            end
        end
    endtask

    task automatic test_timeout_back_to_back();
        xfer_t      x;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_to;
        logic [7:0] e_waits;
        int         e_lat;
        int         e_psel;
        int         e_pen;
        x = '{1'b0, 8'h66, 8'h00, 1000, 8'hFF, 1'b0, 1'b1};
        model(x.wr, x.waits, x.rd, x.err, e_rdata, e_err, e_to, e_waits, e_lat, e_psel, e_pen);
        run_transfer(x);
        n_vec++;
        if ((obs_got_rsp !== 1'b1) || (obs_lat != e_lat) || (obs_pen != e_pen)) begin
            n_err++;
            $display("[TB] FAIL timeout timing: seen=%b lat=%0d pen=%0d expected 1/%0d/%0d",
                     obs_got_rsp, obs_lat, obs_pen, e_lat, e_pen);
        end
        n_vec++;
        if ({obs_to, obs_err, obs_rdata, obs_waits, obs_bus_at_rsp} !== {e_to, e_err, e_rdata, e_waits, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL timeout response: to=%b err=%b rdata=%h waits=%0d bus=%b expected 1/1/00/%0d/0",
                     obs_to, obs_err, obs_rdata, obs_waits, obs_bus_at_rsp, e_waits);
        end
        x = '{1'b1, 8'h67, 8'h3D, 0, 8'h00, 1'b0, 1'b0};
        model(x.wr, x.waits, x.rd, x.err, e_rdata, e_err, e_to, e_waits, e_lat, e_psel, e_pen);
        run_transfer(x);
        n_vec++;
        if ((obs_ready !== 1'b1) || (obs_lat != e_lat) || (obs_psel != e_psel)) begin
            n_err++;
            $display("[TB] FAIL back-to-back accept: ready=%b lat=%0d psel=%0d expected 1/%0d/%0d",
                     obs_ready, obs_lat, obs_psel, e_lat, e_psel);
        end
        n_vec++;
        if ({obs_to, obs_err, obs_waits, obs_stable} !== {e_to, e_err, e_waits, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL back-to-back response: to=%b err=%b waits=%0d stable=%b expected 0/0/0/1",
                     obs_to, obs_err, obs_waits, obs_stable);
        end
        @(posedge pclk);
        #1;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_access();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h3C;
        cmd_wdata = 8'h00;
        pready    = 1'b0;
        pslverr   = 1'b1;
        repeat (4) begin
            @(posedge pclk);
            #1;
        end
        @(negedge pclk);
        n_vec++;
        if ({psel, penable} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL mid-reset setup: psel/penable got %b expected 11", {psel, penable});
        end
        preset = 1'b1;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mid-reset cmd_ready: got %b expected 0", cmd_ready);
        end
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
            n_err++;
            $display("[TB] FAIL mid-reset abort: psel/penable/rsp_valid/cmd_ready got %b expected 0001",
                     {psel, penable, rsp_valid, cmd_ready});
        end
        cmd_write = 1'b1;
        cmd_addr  = 8'h7E;
        cmd_wdata = 8'hA5;
        pslverr   = 1'b0;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b100, 8'h7E, 8'hA5}) begin
            n_err++;
            $display("[TB] FAIL post-reset accept: got %b/%h/%h expected 100/7e/a5",
                     {psel, penable, rsp_valid}, paddr, pwdata);
        end
        pready = 1'b1;
        prdata = 8'h12;
        repeat (2) begin
            @(posedge pclk);
            #1;
        end
        pready = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({rsp_valid, rsp_rdata, rsp_waits, rsp_timeout} !== {1'b1, 8'h00, 8'h00, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL post-reset transfer: valid=%b rdata=%h waits=%0d to=%b expected 1/00/0/0",
                     rsp_valid, rsp_rdata, rsp_waits, rsp_timeout);
        end
    endtask

    // Bound the whole run so a stuck design still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_transfers();
        test_timeout_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB requester that turns a simple one-transfer-at-a-time command interface into AMBA 3 APB transfers toward the AMBA_3_APB slave.
- Drives the SETUP/ACCESS sequencing.
- Honours pready wait states and samples pslverr.
- Returns read data, error and wait-count status on a response strobe.
- A programmable timeout aborts transfers to a hung slave.

Parameters:
ADDR_W, 8, width of paddr/cmd_addr
DATA_W, 8, width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  input  1  clock, all logic on rising edge
preset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block idle, command accepted on edge with cmd_valid
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  DATA_W  read data (0 for writes/timeouts)
rsp_slverr  output  1  slave error or timeout
rsp_timeout  output  1  transfer aborted by timeout
rsp_waits  output  8  wait cycles seen in ACCESS, saturating at 255
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset, sampled on posedge pclk while preset=1:
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_* and the internal wait counter all go to 0.
  - cmd_ready=0 while preset=1.
  - cmd_valid is ignored during reset.
- Reset mid-transfer: psel/penable drop at the next edge. No rsp_valid is produced for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except cmd_ready = (state==IDLE) && !preset.
- IDLE:
  - On an edge with cmd_valid && cmd_ready, latch cmd_addr→paddr, cmd_write→pwrite, cmd_wdata→pwdata.
  - Set psel=1, penable=0, go to SETUP.
- SETUP:
  - Exactly one cycle.
  - Next edge: penable=1, wait counter=0, go to ACCESS.
- ACCESS, edge with pready=1:
  - Transfer completes: psel=0, penable=0, go to IDLE.
  - rsp_valid=1 for one cycle.
  - rsp_slverr=pslverr, rsp_timeout=0, rsp_waits=counter.
  - rsp_rdata=prdata for reads, 0 for writes.
- ACCESS, edge with pready=0:
  - Counter increments, saturating at 255.
  - If TIMEOUT!=0 and the incremented count equals TIMEOUT: abort. psel=penable=0, go to IDLE, rsp_valid=1, rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, rsp_waits=TIMEOUT (saturated to 255).
- Signal stability and sampling:
  - paddr/pwrite/pwdata are constant from SETUP through the end of ACCESS, and hold their last values in IDLE.
  - pslverr and prdata are sampled only on the completing edge and ignored otherwise.
- Latency and throughput:
  - Zero-wait transfer: command accepted at edge N, SETUP during cycle N..N+1, ACCESS sampled at edge N+2, rsp_valid high in cycle N+2..N+3.
  - Throughput is at most one transfer per 3 cycles. A new command can be accepted in the cycle rsp_valid is high, since the block is back in IDLE.
  - rsp_valid has no backpressure. Response fields hold their value until the next response or reset.

Test Plan:
1. Write, no wait:
   - Stimulus: cmd_write=1, addr 0x11, data 0x22; pready=1 in ACCESS.
   - Response: psel high 2 cycles, penable high 1 cycle, paddr=0x11, pwdata=0x22, pwrite=1; rsp_valid one pulse, rsp_waits=0, rsp_slverr=0.
2. Write, 3 waits:
   - Stimulus: addr 0x15, data 0x51; pready low for 3 ACCESS edges, then high.
   - Response: penable high 4 cycles with paddr/pwdata stable; rsp_waits=3, rsp_slverr=0.
3. Read, no wait:
   - Stimulus: addr 0x11; slave returns prdata=0x22 with pready=1.
   - Response: rsp_rdata=0x22, pwrite=0 throughout, rsp_waits=0.
4. Read, error with 2 waits:
   - Stimulus: addr 0x15; prdata=0x5A, pslverr=1 on the ready edge; pslverr=1 during the wait cycles must be ignored.
   - Response: rsp_slverr=1, rsp_rdata=0x5A, rsp_waits=2, rsp_timeout=0.
5. Timeout and back-to-back:
   - Stimulus: TIMEOUT=16, pready held low; then a second command in the same cycle as rsp_valid.
   - Response: abort after 16 ACCESS edges with rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, psel=0. Second command accepted immediately; its SETUP starts the next cycle.
6. Reset mid-ACCESS:
   - Stimulus: assert preset for 1 cycle during a waited read; keep cmd_valid=1 throughout.
   - Response: psel=penable=0 after the reset edge, no rsp_valid, cmd_ready=0 during reset. A new transfer is accepted on the first edge after preset falls.
